i2c_rtc_responder: RTL and testbench

I2C_RTC_RESPONDER -- requirements
Module: i2c_rtc_responder

---
 rtl/i2c_rtc_responder_pkg.sv | 33 +++
 rtl/i2c_line_filter.sv | 64 ++++++
 rtl/i2c_rtc_responder.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_rtc_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_rtc_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_rtc_responder_pkg : shared FSM states, register indices, address     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package i2c_rtc_responder_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_e;

    localparam logic [2:0] REG_SECOND  = 3'd0;
    localparam logic [2:0] REG_MINUTE  = 3'd1;
    localparam logic [2:0] REG_HOUR    = 3'd2;
    localparam logic [2:0] REG_WEEKDAY = 3'd3;
    localparam logic [2:0] REG_DAY     = 3'd4;
    localparam logic [2:0] REG_MONTH   = 3'd5;
    localparam logic [2:0] REG_YEAR    = 3'd6;
    localparam logic [2:0] REG_CONTROL = 3'd7;

    localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h68;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_line_filter : 2-FF synchronizer, N-sample glitch filter, edge strobes|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples disagreeing with the accepted level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
                fall_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2c_rtc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_rtc_responder : I2C target exposing an 8-byte RTC-style register file|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_rtc_responder
    import i2c_rtc_responder_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk14,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen,
    output logic [7:0] ds_second,
    output logic [7:0] ds_minute,
    output logic [7:0] ds_hour,
    output logic [7:0] ds_weekday,
    output logic [7:0] ds_day,
    output logic [7:0] ds_month,
    output logic [7:0] ds_year,
    output logic [7:0] ds_control,
    output logic       updated
);
    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(clk14), .rst_n(reset_n), .line_i(scl_i),
        .level_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(clk14), .rst_n(reset_n), .line_i(sda_i),
        .level_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_e     state_q, state_d;
    logic [7:0] regs_q [8];
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic       written_q, written_d;
    logic       sda_oen_q, sda_oen_d;
    logic       updated_q, updated_d;
    logic       wr_en;

    logic start_det, stop_det, byte_done, addr_match;
    assign start_det  = sda_fall & scl_f;
    assign stop_det   = sda_rise & scl_f;
    assign byte_done  = (bit_cnt_q == 4'd8);
    assign addr_match = (shift_q[7:1] == DEVICE_ADDR);

    always_ff @(posedge clk14 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Byte and ACK phases advance on the SCL falling edge that closes them
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else if (scl_fall) begin
            case (state_q)
                ADDR:      if (byte_done) state_d = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK:  state_d = rw_q ? RDATA : PTR;
                PTR:       if (byte_done) state_d = PTR_ACK;
                PTR_ACK:   state_d = WDATA;
                WDATA:     if (byte_done) state_d = WDATA_ACK;
                WDATA_ACK: state_d = WDATA;
                RDATA:     if (byte_done) state_d = RDATA_ACK;
                RDATA_ACK: state_d = nack_q ? IDLE : RDATA;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        nack_d    = nack_q;
        written_d = written_q;
        sda_oen_d = sda_oen_q;
        updated_d = 1'b0;
        wr_en     = 1'b0;
        if (stop_det) begin
            sda_oen_d = 1'b1;
            bit_cnt_d = 4'd0;
            updated_d = written_q;
            written_d = 1'b0;
        end else if (start_det) begin
            sda_oen_d = 1'b1;
            bit_cnt_d = 4'd0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, PTR, WDATA: if (!byte_done) begin
                    shift_d   = {shift_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                RDATA: if (!byte_done) begin
                    shift_d   = {shift_q[6:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                RDATA_ACK: nack_d = sda_f;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (byte_done) begin
                    rw_d      = shift_q[0];
                    sda_oen_d = ~addr_match;
                    bit_cnt_d = 4'd0;
                end
                ADDR_ACK: begin
                    bit_cnt_d = 4'd0;
                    shift_d   = regs_q[ptr_q];
                    sda_oen_d = rw_q ? regs_q[ptr_q][7] : 1'b1;
                end
                PTR: if (byte_done) begin
                    ptr_d     = shift_q[2:0];
                    sda_oen_d = 1'b0;
                    bit_cnt_d = 4'd0;
                end
                PTR_ACK, WDATA_ACK: begin
                    sda_oen_d = 1'b1;
                    bit_cnt_d = 4'd0;
                end
                WDATA: if (byte_done) begin
                    wr_en     = 1'b1;
                    ptr_d     = ptr_q + 3'd1;
                    written_d = 1'b1;
                    sda_oen_d = 1'b0;
                    bit_cnt_d = 4'd0;
                end
                RDATA: begin
                    if (byte_done) begin
                        ptr_d     = ptr_q + 3'd1;
                        sda_oen_d = 1'b1;
                        bit_cnt_d = 4'd0;
                    end else begin
                        sda_oen_d = shift_q[7];
                    end
                end
                RDATA_ACK: begin
                    bit_cnt_d = 4'd0;
                    shift_d   = regs_q[ptr_q];
                    sda_oen_d = nack_q ? 1'b1 : regs_q[ptr_q][7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk14 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
            shift_q   <= 8'h00;
            bit_cnt_q <= 4'd0;
            ptr_q     <= 3'd0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b1;
            written_q <= 1'b0;
            sda_oen_q <= 1'b1;
            updated_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[ptr_q] <= shift_q;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
            written_q <= written_d;
            sda_oen_q <= sda_oen_d;
            updated_q <= updated_d;
        end
    end

    assign sda_o      = 1'b0;
    assign sda_oen    = sda_oen_q;
    assign updated    = updated_q;
    assign ds_second  = regs_q[REG_SECOND];
    assign ds_minute  = regs_q[REG_MINUTE];
    assign ds_hour    = regs_q[REG_HOUR];
    assign ds_weekday = regs_q[REG_WEEKDAY];
    assign ds_day     = regs_q[REG_DAY];
    assign ds_month   = regs_q[REG_MONTH];
    assign ds_year    = regs_q[REG_YEAR];
    assign ds_control = regs_q[REG_CONTROL];

endmodule
`default_nettype wire

// File: tb/tb_i2c_rtc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_rtc_responder : directed bus-master bench for i2c_rtc_responder   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_i2c_rtc_responder;
    localparam int Q = 15;

    logic       clk14 = 1'b0;
    logic       reset_n;
    logic       scl_m, sda_m;
    logic       sda_o, sda_oen, updated;
    logic [7:0] ds_second, ds_minute, ds_hour, ds_weekday;
    logic [7:0] ds_day, ds_month, ds_year, ds_control;
    logic       sda_bus;
    logic [7:0] ds_arr [8];

    assign sda_bus = sda_m & (sda_oen | sda_o);

    always #5 clk14 = ~clk14;

    i2c_rtc_responder #(.DEVICE_ADDR(7'h68), .FILTER_LEN(3)) dut (
        .clk14(clk14), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_oen(sda_oen),
        .ds_second(ds_second), .ds_minute(ds_minute), .ds_hour(ds_hour),
        .ds_weekday(ds_weekday), .ds_day(ds_day), .ds_month(ds_month),
        .ds_year(ds_year), .ds_control(ds_control), .updated(updated)
    );

    always_comb begin
        ds_arr[0] = ds_second;  ds_arr[1] = ds_minute;
        ds_arr[2] = ds_hour;    ds_arr[3] = ds_weekday;
        ds_arr[4] = ds_day;     ds_arr[5] = ds_month;
        ds_arr[6] = ds_year;    ds_arr[7] = ds_control;
    end

    int upd_cnt   = 0;
    int drive_cnt = 0;
    always @(posedge clk14) begin
        if (updated)  upd_cnt   <= upd_cnt + 1;
        if (!sda_oen) drive_cnt <= drive_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk14);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        if (glitch) begin
            scl_m = 1'b0; wait_clk(1);
            scl_m = 1'b1;
        end
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_bus;  wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack, 1'b0);
    endtask

    typedef struct {
        logic [7:0] ptr_byte;
        logic [7:0] wdata;
        int         idx;
    } vec_t;

    vec_t       vecs [4];
    logic       a0, a1, a2, a3, a4;
    logic [7:0] rd0, rd1, rd2;
    int         u0, d0;
    logic [7:0] or_all;

    initial begin
        // Upper pointer bits are ignored: 0xFE -> 6, 0x85 -> 5
        vecs[0] = '{8'h03, 8'h59, 3};
        vecs[1] = '{8'hFE, 8'hA5, 6};
        vecs[2] = '{8'h07, 8'h24, 7};
        vecs[3] = '{8'h85, 8'h77, 5};

        reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        check("rst_sda_oen", {31'd0, sda_oen}, 32'd1);
        check("rst_sda_o",   {31'd0, sda_o},   32'd0);
        check("rst_updated", {31'd0, updated}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_reg%0d", i), {24'd0, ds_arr[i]}, 32'd0);
        reset_n = 1'b1;
        wait_clk(10);

        // Burst write of seconds/minutes/hours
        u0 = upd_cnt;
        i2c_start();
        write_byte(8'hD0, -1, a0);
        write_byte(8'h00, -1, a1);
        write_byte(8'h45, -1, a2);
        write_byte(8'h30, -1, a3);
        write_byte(8'h12, -1, a4);
        i2c_stop(); wait_clk(10);
        check("burst_acks", {27'd0, a0, a1, a2, a3, a4}, 32'd0);
        check("burst_sec",  {24'd0, ds_second}, 32'h45);
        check("burst_min",  {24'd0, ds_minute}, 32'h30);
        check("burst_hour", {24'd0, ds_hour},   32'h12);
        check("burst_upd",  upd_cnt - u0, 32'd1);

        for (int v = 0; v < 4; v++) begin
            u0 = upd_cnt;
            i2c_start();
            write_byte(8'hD0, -1, a0);
            write_byte(vecs[v].ptr_byte, -1, a1);
            write_byte(vecs[v].wdata, -1, a2);
            i2c_stop(); wait_clk(10);
            check($sformatf("vec%0d_acks", v), {29'd0, a0, a1, a2}, 32'd0);
            check($sformatf("vec%0d_reg", v), {24'd0, ds_arr[vecs[v].idx]}, {24'd0, vecs[v].wdata});
            check($sformatf("vec%0d_upd", v), upd_cnt - u0, 32'd1);
        end

        // Read without pointer phase continues at ptr 6
        i2c_start();
        write_byte(8'hD1, -1, a0);
        read_byte(rd0, 1'b1);
        i2c_stop(); wait_clk(10);
        check("noptr_ack",  {31'd0, a0}, 32'd0);
        check("noptr_data", {24'd0, rd0}, 32'hA5);

        // Pointer 6, repeated start, read with wrap 6,7,0
        u0 = upd_cnt;
        i2c_start();
        write_byte(8'hD0, -1, a0);
        write_byte(8'h06, -1, a1);
        i2c_start();
        write_byte(8'hD1, -1, a2);
        read_byte(rd0, 1'b0);
        read_byte(rd1, 1'b0);
        read_byte(rd2, 1'b1);
        check("wrap_released", {31'd0, sda_oen}, 32'd1);
        i2c_stop(); wait_clk(10);
        check("wrap_acks", {29'd0, a0, a1, a2}, 32'd0);
        check("wrap_rd6",  {24'd0, rd0}, 32'hA5);
        check("wrap_rd7",  {24'd0, rd1}, 32'h24);
        check("wrap_rd0",  {24'd0, rd2}, 32'h45);
        check("wrap_upd",  upd_cnt - u0, 32'd0);

        // Foreign address: never drive SDA
        u0 = upd_cnt; d0 = drive_cnt;
        i2c_start();
        write_byte(8'hA0, -1, a0);
        write_byte(8'h00, -1, a1);
        write_byte(8'h99, -1, a2);
        i2c_stop(); wait_clk(10);
        check("foreign_acks",  {29'd0, a0, a1, a2}, 32'd7);
        check("foreign_drive", drive_cnt - d0, 32'd0);
        check("foreign_sec",   {24'd0, ds_second}, 32'h45);
        check("foreign_upd",   upd_cnt - u0, 32'd0);

        // SCL glitch in bit 3 of the data byte
        i2c_start();
        write_byte(8'hD0, -1, a0);
        write_byte(8'h01, -1, a1);
        write_byte(8'h3C, 3, a2);
        i2c_stop(); wait_clk(10);
        check("glitch_acks", {29'd0, a0, a1, a2}, 32'd0);
        check("glitch_min",  {24'd0, ds_minute}, 32'h3C);

        // Partial byte aborted by STOP
        u0 = upd_cnt;
        i2c_start();
        write_byte(8'hD0, -1, a0);
        write_byte(8'h02, -1, a1);
        for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
        i2c_stop(); wait_clk(10);
        check("partial_hour", {24'd0, ds_hour}, 32'h12);
        check("partial_upd",  upd_cnt - u0, 32'd0);
        i2c_start();
        write_byte(8'hD1, -1, a0);
        read_byte(rd0, 1'b1);
        i2c_stop(); wait_clk(10);
        check("partial_ptr", {24'd0, rd0}, 32'h12);

        // Reset while the responder holds SDA low for reg0 bit7
        i2c_start();
        write_byte(8'hD0, -1, a0);
        write_byte(8'h00, -1, a1);
        i2c_start();
        write_byte(8'hD1, -1, a2);
        check("rdrst_driving", {31'd0, sda_oen}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("rdrst_async_release", {31'd0, sda_oen}, 32'd1);
        wait_clk(3);
        or_all = 8'h00;
        for (int i = 0; i < 8; i++) or_all = or_all | ds_arr[i];
        check("rdrst_regs", {24'd0, or_all}, 32'd0);
        reset_n = 1'b1;
        d0 = drive_cnt;
        write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        i2c_stop(); wait_clk(10);
        check("rdrst_no_drive", drive_cnt - d0, 32'd0);
        u0 = upd_cnt;
        i2c_start();
        write_byte(8'hD0, -1, a0);
        write_byte(8'h00, -1, a1);
        write_byte(8'h11, -1, a2);
        i2c_stop(); wait_clk(10);
        check("rdrst_after_acks", {29'd0, a0, a1, a2}, 32'd0);
        check("rdrst_after_sec",  {24'd0, ds_second}, 32'h11);
        check("rdrst_after_upd",  upd_cnt - u0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
